// File: rtl/mult_seq_ctrl_16x16.sv
// Handshake wrapper around an external sequential 16x16 multiplier:
// drains it after reset, launches one operation per accepted pair and guards the wait with a watchdog.
//
// state | meaning
// INIT  | multiplier drain period after reset or timeout, mult_st held low
// IDLE  | ready for an operand pair
// START | one-cycle mult_st pulse with operands presented
// WAIT  | waiting for mult_done under watchdog
// HOLD  | result presented until the consumer takes it
module mult_seq_ctrl_16x16 #(
  parameter int WDOG_LIMIT  = 63,
  parameter int INIT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_product,
  output logic        err,
  output logic        mult_st,
  output logic [15:0] mult_mplier,
  output logic [15:0] mult_mcand,
  input  logic        mult_done,
  input  logic [31:0] mult_product
);

  localparam int INIT_W = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int WDOG_W = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
  localparam logic [INIT_W-1:0] INIT_TC = INIT_W'(INIT_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_TC = WDOG_W'(WDOG_LIMIT);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                err_q, err_d;
  logic [31:0]         prod_q, prod_d;
  logic [15:0]         a_q, a_d;
  logic [15:0]         b_q, b_d;

  assign wdog_inc = wdog_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    prod_d     = prod_q;
    a_d        = a_q;
    b_d        = b_q;
    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_TC) begin
          state_d = IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = START;
        end
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_inc;
        // A completion on the final allowed cycle still wins over the timeout.
        if (mult_done) begin
          prod_d  = mult_product;
          state_d = HOLD;
        end else if (wdog_inc == WDOG_TC) begin
          err_d      = 1'b1;
          init_cnt_d = '0;
          state_d    = INIT;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        init_cnt_d = '0;
        state_d    = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      prod_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      prod_q     <= prod_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign mult_st     = (state_q == START);
  assign out_product = prod_q;
  assign err         = err_q;
  assign mult_mplier = a_q;
  assign mult_mcand  = b_q;

endmodule

// File: tb/tb_mult_seq_ctrl_16x16.sv
// Randomized bench for mult_seq_ctrl_16x16 with a behavioural multiplier of programmable latency
// and expected products computed directly from the offered operands.
module tb_mult_seq_ctrl_16x16;

  localparam int WDOG_LIMIT  = 63;
  localparam int INIT_CYCLES = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_product;
  logic        err;
  logic        mult_st;
  logic [15:0] mult_mplier;
  logic [15:0] mult_mcand;
  logic        mult_done;
  logic [31:0] mult_product;

  int          checks = 0;
  int          errors = 0;
  int          mult_lat = 4;
  int          rem = 0;
  int          st_count = 0;
  bit          spur_req = 1'b0;
  logic [15:0] op_a, op_b;
  logic [31:0] last_exp = '0;

  mult_seq_ctrl_16x16 #(
    .WDOG_LIMIT (WDOG_LIMIT),
    .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .err         (err),
    .mult_st     (mult_st),
    .mult_mplier (mult_mplier),
    .mult_mcand  (mult_mcand),
    .mult_done   (mult_done),
    .mult_product(mult_product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Multiplier model: latches operands on mult_st, raises mult_done in the
  // mult_lat-th cycle afterwards (never when mult_lat is 0), garbage product otherwise.
  initial begin
    mult_done    = 1'b0;
    mult_product = '0;
    forever begin
      @(negedge clk);
      mult_done    = 1'b0;
      mult_product = $urandom;
      if (mult_st) begin
        st_count++;
        rem  = mult_lat;
        op_a = mult_mplier;
        op_b = mult_mcand;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          mult_done    = 1'b1;
          mult_product = 32'(op_a) * 32'(op_b);
        end
      end else if (spur_req) begin
        mult_done    = 1'b1;
        mult_product = 32'hDEAD_BEEF;
        spur_req     = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic apply_reset(input int cyc, input string tag);
    bit seen_valid = 1'b0;
    bit seen_ready = 1'b0;
    bit seen_st    = 1'b0;
    rst_n = 1'b0;
    repeat (cyc) @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_mult_st"}, {31'd0, mult_st}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_product"}, out_product, 32'd0);
    check({tag, "_operands"}, {mult_mplier, mult_mcand}, 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= INIT_CYCLES; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
      if (in_ready)  seen_ready = 1'b1;
      if (mult_st)   seen_st    = 1'b1;
    end
    check({tag, "_init_early_ready"}, {31'd0, seen_ready}, 32'd0);
    check({tag, "_init_no_valid"}, {31'd0, seen_valid}, 32'd0);
    check({tag, "_init_no_st"}, {31'd0, seen_st}, 32'd0);
    @(negedge clk);
    check({tag, "_init_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int lat, input int hold);
    logic [31:0] exp;
    int st0;
    int n;
    exp      = 32'(a) * 32'(b);
    last_exp = exp;
    mult_lat = lat;
    wait_ready();
    st0       = st_count;
    out_ready = (hold == 0);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    n        = 1;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, lat + 2);
    check("product", out_product, exp);
    check("operands", {mult_mplier, mult_mcand}, {a, b});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_product", out_product, exp);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("st_pulses", st_count - st0, 32'd1);
  endtask

  task automatic timeout_op();
    int n = 0;
    bit seen_valid = 1'b0;
    check("err_before_timeout", {31'd0, err}, 32'd0);
    mult_lat = 0;
    wait_ready();
    in_a     = 16'h0042;
    in_b     = 16'h0017;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!err && n < 300) begin
      @(negedge clk);
      n++;
      if (out_valid) seen_valid = 1'b1;
    end
    check("wdog_cycles", n, WDOG_LIMIT + 1);
    check("wdog_no_valid", {31'd0, seen_valid}, 32'd0);
    check("wdog_in_ready", {31'd0, in_ready}, 32'd0);
    wait_ready();
    check("wdog_err_sticky", {31'd0, err}, 32'd1);
    do_op(16'd9, 16'd9, 3, 0);
    check("wdog_err_after_op", {31'd0, err}, 32'd1);
  endtask

  task automatic reset_mid_wait();
    mult_lat = 20;
    wait_ready();
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    apply_reset(1, "midwait");
    check("midwait_err", {31'd0, err}, 32'd0);
    check("midwait_product", out_product, 32'd0);
  endtask

  initial begin
    apply_reset(2, "por");

    do_op(16'd3, 16'd5, 4, 0);
    check("scn_3x5", last_exp, 32'h0000_000F);
    do_op(16'hFFFF, 16'hFFFF, 6, 0);
    do_op(16'h0000, 16'h1234, 2, 0);
    do_op(16'h00AB, 16'h00CD, 5, 10);

    do_op(16'd2, 16'd7, 1, 0);
    do_op(16'd100, 16'd100, 3, 0);
    do_op(16'h8000, 16'd2, 2, 0);

    do_op(16'($urandom), 16'($urandom), WDOG_LIMIT, 0);
    check("boundary_err", {31'd0, err}, 32'd0);

    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_no_valid", {31'd0, out_valid}, 32'd0);
    check("spur_product", out_product, last_exp);

    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(16'($urandom), 16'($urandom), $urandom_range(1, 20), $urandom_range(0, 3));
    end

    timeout_op();
    reset_mid_wait();
    do_op(16'h0123, 16'h0456, 7, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
